irq_priority_encoder: RTL and testbench
=======================================

# irq_priority_encoder

Eight-level priority interrupt encoder with latched requests and an acknowledge/end-of-interrupt handshake. It is the encoding counterpart of the active-low decoder outputs used across the board, similar in role to a 74148 or 8214 front end but fully clocked. It collects up to eight active-low request lines and presents the highest eligible level as an active-low 3-bit code with an interrupt strobe to the CPU sequencer. It tracks nested in-service levels so that only a higher-priority request can interrupt one already being serviced.

## Interface
- SYNC_STAGES, 2, synchronizer depth on `req_n` (valid values are 2 or more).
- EDGE_TRIG, 0, 0 = level-sensitive requests; 1 = requests latched on the falling edge of `req_n`.

- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_n  input  8  asynchronous requests, active low; bit 7 is the highest priority.
- mask  input  8  synchronous, active high; a set bit makes that level ineligible.
- ack  input  1  synchronous, one-cycle pulse; the CPU accepts the presented code.
- eoi  input  1  synchronous, one-cycle pulse; end of interrupt.
- int_n  output  1  interrupt strobe, active low, registered.
- code_n  output  3  active-low index of the presented level, registered.
- in_service  output  8  in-service register.
- busy  output  1  high while `in_service` is non-zero.

## Operation
- Each `req_n` bit passes through SYNC_STAGES flops. These flops reset to 1. Let `req` be the inverted synchronizer output.
- Pending register `pend[7:0]`:
  - EDGE_TRIG=0: `pend <= req` every cycle.
  - EDGE_TRIG=1: `pend[i]` is set on a 0→1 transition of `req[i]`. It is cleared when level i is acknowledged. Set takes precedence over clear in the same cycle.
  - Masked levels are still latched.
- Eligibility: `elig[i] = pend[i] & ~mask[i] & (i > highest set bit of in_service)`. Every level is above an empty `in_service`.
- Winner: the highest set bit of `elig`.
- State machine:
  - IDLE:
    - `int_n`=1, `code_n`=3'b111.
    - If `elig` is non-zero: register the winner into `vec`, drive `int_n`=0 and `code_n`=~vec, then go to ASSERT.
    - `ack` is ignored in IDLE.
  - ASSERT:
    - `vec` is frozen; there is no re-arbitration, even if a higher level arrives.
    - On `ack`: set `in_service[vec]`. If EDGE_TRIG=1, clear `pend[vec]`. Drive `int_n`=1 and `code_n`=3'b111, then go to IDLE.
    - Withdrawal: if `ack`=0 and (`pend[vec]`=0 or `mask[vec]`=1), drive `int_n`=1 and `code_n`=3'b111, then go to IDLE. No ISR bit changes.
- EOI:
  - Clears the highest set bit of `in_service`. It is accepted in any state.
  - If `in_service`=0, EOI is a no-op.
  - If `ack` and `eoi` arrive in the same cycle: `in_service_next = (in_service & ~highest(in_service)) | onehot(vec)`.
- Eligibility uses the registered `in_service`, so an EOI affects arbitration from the following cycle.
- `busy = |in_service`, registered together with `in_service`.
- Reset forces, immediately and regardless of the clock:
  - all state to IDLE;
  - `int_n`=1, `code_n`=3'b111;
  - `in_service`=0, `busy`=0, `pend`=0, `vec`=0;
  - synchronizer flops to 1.
- A reset during ASSERT drops `int_n` with no acknowledge recorded.

## Timing
- Request latency: `req_n` first sampled low at edge N gives `pend` set after edge N+SYNC_STAGES and `int_n`=0 after edge N+SYNC_STAGES+1. With the default depth this is 3 edges.
- Acknowledge: `ack` sampled at edge M gives `int_n`=1 and the `in_service` bit set after edge M. The next `int_n`=0 comes no earlier than after edge M+1, so the strobe is high for at least one cycle between grants.
- `code_n` is valid for the whole time `int_n`=0 and is stable until `ack` or withdrawal.
- Withdrawal: `int_n` rises one edge after `pend[vec]` clears or `mask[vec]` sets.
- Level mode: if a request is still asserted after `ack`, it becomes eligible again only once its `in_service` bit is cleared by EOI (nesting rule).

## Test plan
- Reset check: assert `rst` mid-ASSERT → outputs go immediately to `int_n`=1, `code_n`=3'b111, `in_service`=8'h00, `busy`=0.
- Single request: `req_n`=8'hFB → `int_n`=0 after 3 edges with `code_n`=3'b101. Pulse `ack` → `in_service`=8'h04, `busy`=1, `int_n`=1. Pulse `eoi` → `in_service`=8'h00.
- Simultaneous and nested requests:
  - `req_n`=8'hBD (levels 6 and 1) → `code_n`=3'b001 (level 6). After `ack`, level 1 stays held off.
  - `eoi` → `code_n`=3'b110 (level 1).
  - Nesting: with level 2 in service, request level 5 → `int_n`=0 with `code_n`=3'b010. Then `ack`, `eoi`, `eoi` → `in_service` steps 8'h24 → 8'h04 → 8'h00.
- Mask:
  - `mask`=8'h40 with levels 6 and 3 requested → `code_n`=3'b100 (level 3).
  - Set `mask[3]` during ASSERT → `int_n`=1 one edge later and `in_service` is unchanged.
- Same-cycle `ack` and `eoi`: `in_service`=8'h04, pending level 7 presented, pulse `ack` and `eoi` together → `in_service`=8'h80.
- EDGE_TRIG=1:
  - Hold `req_n[4]` low → exactly one grant with `code_n`=3'b011. After `ack`+`eoi` there is no re-grant while it stays low.
  - Release and reassert `req_n[4]` → a new grant after 3 edges.

Source files
------------

// File: rtl/irq_priority_encoder.sv
// Eight-level priority interrupt encoder: synchronised active-low requests, nested
// in-service tracking, and an ack/EOI handshake toward the CPU sequencer.
//
// state  | meaning
// IDLE   | no code presented; arbitrates eligible levels every cycle
// ASSERT | int_n low, code_n holds the frozen winner until ack or withdrawal
module irq_priority_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_n,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic       eoi,
    output logic       int_n,
    output logic [2:0] code_n,
    output logic [7:0] in_service,
    output logic       busy
);

    typedef enum logic {IDLE, ASSERT} state_t;

    state_t     state_q, state_d;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] req;
    logic [7:0] req_q;
    logic [7:0] pend_q, pend_d;
    logic [2:0] vec_q, vec_d;
    logic       int_n_q, int_n_d;
    logic [2:0] code_n_q, code_n_d;
    logic [7:0] isr_q, isr_d;
    logic       busy_q, busy_d;

    logic [7:0] isr_top;
    logic [7:0] above;
    logic [7:0] elig;
    logic [2:0] winner;
    logic [7:0] vec_oh;
    logic       ack_take;
    logic       seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 8'hFF;
            end
        end else begin
            sync_q[0] <= req_n;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign req    = ~sync_q[SYNC_STAGES-1];
    assign vec_oh = 8'b1 << vec_q;

    // above[i] is set when no in-service bit sits at level i or higher.
    always_comb begin
        isr_top = 8'h00;
        above   = 8'h00;
        seen    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (isr_q[i]) begin
                isr_top = 8'b1 << i;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            seen     = seen | isr_q[i];
            above[i] = ~seen;
        end
    end

    assign elig = pend_q & ~mask & above;

    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (elig[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        int_n_d  = int_n_q;
        code_n_d = code_n_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                int_n_d  = 1'b1;
                code_n_d = 3'b111;
                if (|elig) begin
                    vec_d    = winner;
                    int_n_d  = 1'b0;
                    code_n_d = ~winner;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (ack) begin
                    ack_take = 1'b1;
                    int_n_d  = 1'b1;
                    code_n_d = 3'b111;
                    state_d  = IDLE;
                end else if (!pend_q[vec_q] || mask[vec_q]) begin
                    int_n_d  = 1'b1;
                    code_n_d = 3'b111;
                    state_d  = IDLE;
                end
            end
            default: begin
                int_n_d  = 1'b1;
                code_n_d = 3'b111;
                state_d  = IDLE;
            end
        endcase
    end

    // In edge mode a fresh rising request wins over the clear from an ack.
    always_comb begin
        if (EDGE_TRIG) begin
            pend_d = pend_q;
            if (ack_take) begin
                pend_d = pend_d & ~vec_oh;
            end
            pend_d = pend_d | (req & ~req_q);
        end else begin
            pend_d = req;
        end
    end

    always_comb begin
        isr_d = isr_q;
        if (eoi) begin
            isr_d = isr_d & ~isr_top;
        end
        if (ack_take) begin
            isr_d = isr_d | vec_oh;
        end
        busy_d = |isr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 8'h00;
            pend_q   <= 8'h00;
            vec_q    <= 3'd0;
            int_n_q  <= 1'b1;
            code_n_q <= 3'b111;
            isr_q    <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req;
            pend_q   <= pend_d;
            vec_q    <= vec_d;
            int_n_q  <= int_n_d;
            code_n_q <= code_n_d;
            isr_q    <= isr_d;
            busy_q   <= busy_d;
        end
    end

    assign int_n      = int_n_q;
    assign code_n     = code_n_q;
    assign in_service = isr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle stamps,
// a monitor pops one entry each time a DUT's output tuple changes.
module tb_irq_priority_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;

    logic [7:0] req_n_l = 8'hFF, mask_l = 8'h00;
    logic       ack_l = 1'b0, eoi_l = 1'b0;
    logic       int_n_l, busy_l;
    logic [2:0] code_n_l;
    logic [7:0] isr_l;

    logic [7:0] req_n_e = 8'hFF, mask_e = 8'h00;
    logic       ack_e = 1'b0, eoi_e = 1'b0;
    logic       int_n_e, busy_e;
    logic [2:0] code_n_e;
    logic [7:0] isr_e;

    typedef struct {
        int          cyc;
        logic [12:0] val;
    } exp_t;

    exp_t        q_l[$];
    exp_t        q_e[$];
    logic [12:0] prev_l = 13'h1E00;
    logic [12:0] prev_e = 13'h1E00;
    int          n_cmp = 0;
    int          n_bad = 0;

    irq_priority_encoder #(.SYNC_STAGES(2), .EDGE_TRIG(1'b0)) u_lvl (
        .clk(clk), .rst(rst), .req_n(req_n_l), .mask(mask_l), .ack(ack_l), .eoi(eoi_l),
        .int_n(int_n_l), .code_n(code_n_l), .in_service(isr_l), .busy(busy_l)
    );

    irq_priority_encoder #(.SYNC_STAGES(2), .EDGE_TRIG(1'b1)) u_edg (
        .clk(clk), .rst(rst), .req_n(req_n_e), .mask(mask_e), .ack(ack_e), .eoi(eoi_e),
        .int_n(int_n_e), .code_n(code_n_e), .in_service(isr_e), .busy(busy_e)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] mk(input logic i_n, input logic [2:0] c,
                                       input logic [7:0] s, input logic b);
        return {i_n, c, s, b};
    endfunction

    task automatic exp_push(input int d, input int dly, input logic [12:0] v);
        exp_t e;
        e.cyc = cyc + dly;
        e.val = v;
        if (d == 0) q_l.push_back(e);
        else        q_e.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void observe(input int d, input logic [12:0] o);
        exp_t  e;
        string nm;
        nm = (d == 0) ? "lvl" : "edge";
        if (d == 0) begin
            if (o === prev_l) return;
            prev_l = o;
        end else begin
            if (o === prev_e) return;
            prev_e = o;
        end
        n_cmp++;
        if ((d == 0 && q_l.size() == 0) || (d == 1 && q_e.size() == 0)) begin
            n_bad++;
            $display("FAIL %s_unexpected cyc=%0d got int_n=%b code_n=%b isr=%h busy=%b, required no change",
                     nm, cyc, o[12], o[11:9], o[8:1], o[0]);
            return;
        end
        e = (d == 0) ? q_l.pop_front() : q_e.pop_front();
        if (e.val !== o || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL %s_out cyc=%0d got int_n=%b code_n=%b isr=%h busy=%b, required int_n=%b code_n=%b isr=%h busy=%b at cyc=%0d",
                     nm, cyc, o[12], o[11:9], o[8:1], o[0],
                     e.val[12], e.val[11:9], e.val[8:1], e.val[0], e.cyc);
        end
    endfunction

    initial begin
        @(negedge rst);
        forever begin
            @(negedge clk or posedge rst);
            #1;
            observe(0, {int_n_l, code_n_l, isr_l, busy_l});
            observe(1, {int_n_e, code_n_e, isr_e, busy_e});
        end
    end

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        // single request, level 2
        req_n_l = 8'hFB; exp_push(0, 4, mk(1'b0, 3'b101, 8'h00, 1'b0)); step(4);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h04, 1'b1)); step(1);
        ack_l = 1'b0; req_n_l = 8'hFF; step(4);
        eoi_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(1);
        eoi_l = 1'b0; step(2);

        // levels 6 and 1 together; level 1 held off until EOI
        req_n_l = 8'hBD; exp_push(0, 4, mk(1'b0, 3'b001, 8'h00, 1'b0)); step(4);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h40, 1'b1)); step(1);
        ack_l = 1'b0; step(3);
        req_n_l = 8'hFD; step(4);
        eoi_l = 1'b1;
        exp_push(0, 1, mk(1'b1, 3'b111, 8'h00, 1'b0));
        exp_push(0, 2, mk(1'b0, 3'b110, 8'h00, 1'b0));
        step(1);
        eoi_l = 1'b0; step(1);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h02, 1'b1)); step(1);
        ack_l = 1'b0; req_n_l = 8'hFF; step(4);
        eoi_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(1);
        eoi_l = 1'b0; step(2);

        // nesting: level 5 interrupts level 2
        req_n_l = 8'hFB; exp_push(0, 4, mk(1'b0, 3'b101, 8'h00, 1'b0)); step(4);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h04, 1'b1)); step(1);
        ack_l = 1'b0; req_n_l = 8'hDB; exp_push(0, 4, mk(1'b0, 3'b010, 8'h04, 1'b1)); step(4);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h24, 1'b1)); step(1);
        ack_l = 1'b0; req_n_l = 8'hFF; step(4);
        eoi_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h04, 1'b1)); step(1);
        eoi_l = 1'b0; step(1);
        eoi_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(1);
        eoi_l = 1'b0; step(2);

        // mask: level 6 masked, level 3 wins, then withdrawn by masking it
        mask_l = 8'h40; req_n_l = 8'hB7; exp_push(0, 4, mk(1'b0, 3'b100, 8'h00, 1'b0)); step(4);
        mask_l = 8'h48; exp_push(0, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(3);
        req_n_l = 8'hFF; step(4);
        mask_l = 8'h00; step(2);

        // same-cycle ack and eoi
        req_n_l = 8'hFB; exp_push(0, 4, mk(1'b0, 3'b101, 8'h00, 1'b0)); step(4);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h04, 1'b1)); step(1);
        ack_l = 1'b0; req_n_l = 8'h7B; exp_push(0, 4, mk(1'b0, 3'b000, 8'h04, 1'b1)); step(4);
        ack_l = 1'b1; eoi_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h80, 1'b1)); step(1);
        ack_l = 1'b0; eoi_l = 1'b0; req_n_l = 8'hFF; step(4);
        eoi_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(1);
        eoi_l = 1'b0; step(2);

        // asynchronous reset while asserting with a level in service
        req_n_l = 8'hFD; exp_push(0, 4, mk(1'b0, 3'b110, 8'h00, 1'b0)); step(4);
        ack_l = 1'b1; exp_push(0, 1, mk(1'b1, 3'b111, 8'h02, 1'b1)); step(1);
        ack_l = 1'b0; req_n_l = 8'hED; exp_push(0, 4, mk(1'b0, 3'b011, 8'h02, 1'b1)); step(5);
        exp_push(0, 0, mk(1'b1, 3'b111, 8'h00, 1'b0));
        #2;
        rst = 1'b1; req_n_l = 8'hFF;
        step(2);
        rst = 1'b0; step(3);

        // edge-triggered instance: one grant per falling edge of req_n[4]
        req_n_e = 8'hEF; exp_push(1, 4, mk(1'b0, 3'b011, 8'h00, 1'b0)); step(4);
        ack_e = 1'b1; exp_push(1, 1, mk(1'b1, 3'b111, 8'h10, 1'b1)); step(1);
        ack_e = 1'b0; step(3);
        eoi_e = 1'b1; exp_push(1, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(1);
        eoi_e = 1'b0; step(6);
        req_n_e = 8'hFF; step(3);
        req_n_e = 8'hEF; exp_push(1, 4, mk(1'b0, 3'b011, 8'h00, 1'b0)); step(4);
        ack_e = 1'b1; exp_push(1, 1, mk(1'b1, 3'b111, 8'h10, 1'b1)); step(1);
        ack_e = 1'b0; req_n_e = 8'hFF; step(3);
        eoi_e = 1'b1; exp_push(1, 1, mk(1'b1, 3'b111, 8'h00, 1'b0)); step(1);
        eoi_e = 1'b0; step(4);

        n_cmp++;
        if (q_l.size() != 0) begin
            n_bad++;
            $display("FAIL lvl_drain got %0d outstanding changes, required 0", q_l.size());
        end
        n_cmp++;
        if (q_e.size() != 0) begin
            n_bad++;
            $display("FAIL edge_drain got %0d outstanding changes, required 0", q_e.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
